// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: takes WIDTH-bit words over ready/valid and
// emits them one bit per clock as a valid/d_out bitstream. A one-word holding
// register lets the next word queue up so consecutive words stream gaplessly.
module bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             valid,
    output logic             d_out,
    output logic             last
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic             hold_full_q, hold_full_d;

    logic             accept;
    logic [WIDTH-1:0] sh_shifted;

    // Handshake: ready depends only on registers and reset, never on in_valid.
    assign in_ready = rst & ~hold_full_q;
    assign accept   = in_valid & in_ready;

    // Serial outputs decoded straight from the registers.
    assign valid = (state_q == StShift);
    assign d_out = valid ? (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]) : 1'b0;
    assign last  = valid & (cnt_q == CntLast);

    // Shift one position toward the output end, zero-filled.
    always_comb begin
        sh_shifted = '0;
        if (MSB_FIRST) begin
            sh_shifted = {sh_q[WIDTH-2:0], 1'b0};
        end else begin
            sh_shifted = {1'b0, sh_q[WIDTH-1:1]};
        end
    end

    // Next-state logic: load, shift, queue into hold, reload at word boundary.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;

        unique case (state_q)
            StIdle: begin
                // Hold register is always empty here, so accepts go straight to sh.
                if (accept) begin
                    sh_d    = in_data;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (cnt_q != CntLast) begin
                    cnt_d = cnt_q + CntW'(1);
                    sh_d  = sh_shifted;
                    if (accept) begin
                        hold_data_d = in_data;
                        hold_full_d = 1'b1;
                    end
                end else begin
                    // Word boundary: a queued word wins; accept cannot coincide
                    // with a full hold because in_ready is low then.
                    cnt_d = '0;
                    if (hold_full_q) begin
                        sh_d        = hold_data_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        sh_d = in_data;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset drops any word in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            sh_q        <= '0;
            cnt_q       <= '0;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an 8-bit MSB-first instance and a 4-bit
// LSB-first instance. Accepted words are expanded into expected bits on a
// scoreboard queue and popped as valid bits appear on d_out.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst;

    logic       in_valid8;
    logic [7:0] in_data8;
    logic       in_ready8, valid8, d_out8, last8;

    logic       in_valid4;
    logic [3:0] in_data4;
    logic       in_ready4, valid4, d_out4, last4;

    int checks = 0;
    int errors = 0;

    // Each entry: {expected bit, expected last}
    logic [1:0] q8[$];
    logic [1:0] q4[$];

    // Per-cycle histories, newest sample in bit 0.
    logic [31:0] vhist8, lhist8, vhist4, lhist4, dhist4;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid8),
        .in_data  (in_data8),
        .in_ready (in_ready8),
        .valid    (valid8),
        .d_out    (d_out8),
        .last     (last8)
    );

    bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid4),
        .in_data  (in_data4),
        .in_ready (in_ready4),
        .valid    (valid4),
        .d_out    (d_out4),
        .last     (last4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push8(input logic [7:0] w);
        for (int i = 0; i < 8; i++) q8.push_back({w[7-i], i == 7});
    endtask

    task automatic push4(input logic [3:0] w);
        for (int i = 0; i < 4; i++) q4.push_back({w[i], i == 3});
    endtask

    task automatic clear_hist();
        vhist8 = '0; lhist8 = '0; vhist4 = '0; lhist4 = '0; dhist4 = '0;
    endtask

    // One clock: log handshakes before the edge, then sample and score #1 after it.
    task automatic tick();
        logic a8, a4, r;
        logic [1:0] e;
        a8 = in_valid8 && in_ready8;
        a4 = in_valid4 && in_ready4;
        r  = rst;
        if (a8) push8(in_data8);
        if (a4) push4(in_data4);
        @(posedge clk);
        #1;
        if (!r) begin
            q8.delete();
            q4.delete();
        end
        vhist8 = {vhist8[30:0], valid8};
        lhist8 = {lhist8[30:0], last8};
        vhist4 = {vhist4[30:0], valid4};
        lhist4 = {lhist4[30:0], last4};
        dhist4 = {dhist4[30:0], d_out4};
        if (valid8) begin
            if (q8.size() == 0) begin
                check("spurious_valid8", 32'(valid8), 32'd0);
            end else begin
                e = q8.pop_front();
                check("d_out8", 32'(d_out8), 32'(e[1]));
                check("last8", 32'(last8), 32'(e[0]));
            end
        end else begin
            check("idle_d_out8", 32'(d_out8), 32'd0);
            check("idle_last8", 32'(last8), 32'd0);
        end
        if (valid4) begin
            if (q4.size() == 0) begin
                check("spurious_valid4", 32'(valid4), 32'd0);
            end else begin
                e = q4.pop_front();
                check("d_out4", 32'(d_out4), 32'(e[1]));
                check("last4", 32'(last4), 32'(e[0]));
            end
        end else begin
            check("idle_d_out4", 32'(d_out4), 32'd0);
            check("idle_last4", 32'(last4), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b0;
        in_valid8 = 1'b0; in_data8 = '0;
        in_valid4 = 1'b0; in_data4 = '0;
        clear_hist();

        // Reset state
        tick();
        tick();
        check("rst_valid8", 32'(valid8), 32'd0);
        check("rst_d_out8", 32'(d_out8), 32'd0);
        check("rst_last8", 32'(last8), 32'd0);
        check("rst_in_ready8", 32'(in_ready8), 32'd0);
        check("rst_in_ready4", 32'(in_ready4), 32'd0);
        rst = 1'b1;
        #1;
        check("release_in_ready8", 32'(in_ready8), 32'd1);
        check("release_in_ready4", 32'(in_ready4), 32'd1);

        // Single word MSB first: 8'hB5
        clear_hist();
        in_valid8 = 1'b1; in_data8 = 8'hB5;
        tick();
        in_valid8 = 1'b0;
        repeat (9) tick();
        check("single_valid_hist", vhist8, 32'h0000_03FC);
        check("single_last_hist", lhist8, 32'h0000_0004);

        // Back-to-back gapless: 8'hA0 then 8'h0F
        clear_hist();
        in_valid8 = 1'b1; in_data8 = 8'hA0;
        tick();
        in_data8 = 8'h0F;
        tick();
        in_valid8 = 1'b0;
        check("b2b_in_ready_held", 32'(in_ready8), 32'd0);
        repeat (16) tick();
        check("b2b_valid_hist", vhist8, 32'h0003_FFFC);
        check("b2b_last_hist", lhist8, 32'h0000_0404);

        // Hold full with three words presented back to back
        clear_hist();
        in_valid8 = 1'b1; in_data8 = 8'h11;
        tick();
        in_data8 = 8'h22;
        tick();
        in_data8 = 8'h33;
        check("hold_in_ready_t1", 32'(in_ready8), 32'd0);
        for (int t = 2; t <= 8; t++) begin
            tick();
            check($sformatf("hold_in_ready_t%0d", t), 32'(in_ready8), 32'(t == 8));
        end
        tick();
        in_valid8 = 1'b0;
        check("hold_refilled", 32'(in_ready8), 32'd0);
        repeat (16) tick();
        check("hold_valid_hist", vhist8, 32'h03FF_FFFC);

        // LSB first, WIDTH=4: 4'h1
        clear_hist();
        in_valid4 = 1'b1; in_data4 = 4'h1;
        tick();
        in_valid4 = 1'b0;
        repeat (5) tick();
        check("lsb_valid_hist", vhist4, 32'h0000_003C);
        check("lsb_last_hist", lhist4, 32'h0000_0004);
        check("lsb_data_hist", dhist4, 32'h0000_0020);

        // Reset mid-word: 8'hFF shifting, 8'h0F held
        clear_hist();
        in_valid8 = 1'b1; in_data8 = 8'hFF;
        tick();
        in_data8 = 8'h0F;
        tick();
        in_valid8 = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("midrst_valid", 32'(valid8), 32'd0);
        check("midrst_d_out", 32'(d_out8), 32'd0);
        check("midrst_in_ready", 32'(in_ready8), 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_release_ready", 32'(in_ready8), 32'd1);
        clear_hist();
        repeat (5) tick();
        check("midrst_no_resume", vhist8, 32'h0000_0000);

        // Late second word: accepted one edge after the boundary edge
        clear_hist();
        in_valid8 = 1'b1; in_data8 = 8'hC3;
        tick();
        in_valid8 = 1'b0;
        repeat (8) tick();
        in_valid8 = 1'b1; in_data8 = 8'h5A;
        tick();
        in_valid8 = 1'b0;
        repeat (8) tick();
        check("late_valid_hist", vhist8, 32'h0003_FDFE);

        // Every accepted bit must have been emitted
        check("drain_q8", 32'(q8.size()), 32'd0);
        check("drain_q4", 32'(q4.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
